// File: rtl/instr_player_pkg.sv
// Shared encodings and defaults for the instruction stream player.
package instr_player_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ISSUE = S_ISSUE;
  localparam logic [1:0] ST_HOLD  = S_HOLD;
  localparam logic [1:0] ST_DONE  = S_DONE;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam int          DEFAULT_HOLD = 1;

endpackage

// File: rtl/instr_player_misr.sv
// Multiple-input signature register compacting processor output samples.
module instr_player_misr
  import instr_player_pkg::*;
#(
  parameter int               OBS_W = 16,
  parameter logic [OBS_W-1:0] POLY  = OBS_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OBS_W-1:0] obs_i,
  output logic [OBS_W-1:0] sig_o
);

  logic [OBS_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[OBS_W-2:0], 1'b0} ^ (sig_q[OBS_W-1] ? POLY : '0) ^ obs_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/instr_stream_player.sv
// Plays a preloaded instruction sequence into a processor IR over valid/ready.
// Optional signature compaction of processor output: INSTR_STREAM_SIG_EN.
module instr_stream_player
  import instr_player_pkg::*;
#(
  parameter int               IR_W  = 6,
  parameter int               DEPTH = 56,
  parameter int               OBS_W = 16,
  parameter int               HOLD  = DEFAULT_HOLD,
  parameter logic [OBS_W-1:0] POLY  = OBS_W'(DEFAULT_POLY),
  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [AW:0]      len,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [IR_W-1:0]  load_data,
  output logic [IR_W-1:0]  ir_out,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic [OBS_W-1:0] obs_in,
  input  logic             obs_valid,
  output logic [AW:0]      idx,
  output logic             busy,
  output logic             done,
  output logic [OBS_W-1:0] signature,
  output logic [1:0]       dbg_state
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [7:0]  HOLD_M1 = 8'(HOLD - 1);

  logic [1:0]      state_q, state_d;
  logic [AW:0]     idx_q, idx_d, len_q, len_d;
  logic [7:0]      hold_q, hold_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            done_q, done_d;
  logic            step;
  logic [IR_W-1:0] mem_q [DEPTH];

  logic            idle_like, wr_en, go, last;
  logic [AW:0]     eff_len, idx_inc;
  logic [IR_W-1:0] first_instr, next_instr;

  assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign wr_en       = idle_like && load_we && ({1'b0, load_addr} < DEPTH_L);
  assign go          = idle_like && start;
  assign eff_len     = (len > DEPTH_L) ? DEPTH_L : len;
  // A same-cycle write to entry 0 must be visible to the instruction issued first.
  assign first_instr = (wr_en && load_addr == '0) ? load_data : mem_q[0];
  assign idx_inc     = idx_q + 1'b1;
  assign last        = (idx_inc == len_q);
  assign next_instr  = mem_q[idx_inc[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[load_addr] <= load_data;
  end

  // ir_valid/ir_ready: an instruction transfers on a rising edge where both are
  // high; while ir_valid waits for ir_ready, ir_out and idx are held steady.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hold_d  = hold_q;
    ir_d    = ir_q;
    done_d  = done_q;
    step    = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ir_ready) begin
          if (HOLD_M1 != 8'd0) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_M1;
          end else begin
            step = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (hold_q == 8'd1) begin
          hold_d = '0;
          step   = 1'b1;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        if (go) begin
          idx_d  = '0;
          len_d  = eff_len;
          hold_d = '0;
          if (eff_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            done_d  = 1'b0;
            ir_d    = first_instr;
          end
        end
      end
    endcase
    if (step) begin
      idx_d = idx_inc;
      if (last) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_ISSUE;
        ir_d    = next_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
    end
  end

  assign ir_out    = ir_q;
  assign ir_valid  = (state_q == ST_ISSUE);
  assign idx       = idx_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_HOLD);
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef INSTR_STREAM_SIG_EN
  instr_player_misr #(
    .OBS_W (OBS_W),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (go),
    .en_i  (busy && obs_valid),
    .obs_i (obs_in),
    .sig_o (signature)
  );
`else
  logic unused_obs;
  assign unused_obs = ^{obs_in, obs_valid, POLY};
  assign signature  = '0;
`endif

endmodule

// File: tb/tb_instr_stream_player.sv
// Randomized and directed bench for instr_stream_player (HOLD=1 and HOLD=3 copies).
module tb_instr_stream_player;
  import instr_player_pkg::*;

  localparam int DEPTH = 56;
  localparam int AW    = 6;
  localparam int IR_W  = 6;
  localparam int OBS_W = 16;
  localparam logic [15:0] POLY = 16'h1021;
`ifdef INSTR_STREAM_SIG_EN
  localparam logic [15:0] SIG_LIT = 16'h0003;
`else
  localparam logic [15:0] SIG_LIT = 16'h0000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0, abort = 1'b0, load_we = 1'b0, ir_ready = 1'b0, obs_valid = 1'b0;
  logic [AW:0]      len = '0;
  logic [AW-1:0]    load_addr = '0;
  logic [IR_W-1:0]  load_data = '0;
  logic [OBS_W-1:0] obs_in = '0;

  logic [IR_W-1:0]  ir_out [2];
  logic             ir_valid [2];
  logic             busy [2];
  logic             done [2];
  logic [AW:0]      idx [2];
  logic [OBS_W-1:0] signature [2];
  logic [1:0]       dbg_state [2];

  instr_stream_player #(.HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .ir_out(ir_out[0]), .ir_valid(ir_valid[0]), .ir_ready(ir_ready),
    .obs_in(obs_in), .obs_valid(obs_valid), .idx(idx[0]), .busy(busy[0]),
    .done(done[0]), .signature(signature[0]), .dbg_state(dbg_state[0])
  );

  instr_stream_player #(.HOLD(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .ir_out(ir_out[1]), .ir_valid(ir_valid[1]), .ir_ready(ir_ready),
    .obs_in(obs_in), .obs_valid(obs_valid), .idx(idx[1]), .busy(busy[1]),
    .done(done[1]), .signature(signature[1]), .dbg_state(dbg_state[1])
  );

  // behavioural model: a play cursor, a post-accept gap counter, per-copy memory
  int              hold_of [2] = '{1, 3};
  logic [IR_W-1:0] m_mem [2][DEPTH];
  bit              m_play [2];
  bit              m_done [2];
  int              m_pos [2], m_len [2], m_gap [2];
  logic [IR_W-1:0] m_ir [2];
  logic [15:0]     m_sig [2];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s copy%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_play[k] = 0; m_done[k] = 0; m_pos[k] = 0; m_len[k] = 0;
      m_gap[k] = 0; m_ir[k] = '0; m_sig[k] = '0;
    end
  endtask

  task automatic finish_one(input int k);
    m_pos[k]++;
    if (m_pos[k] == m_len[k]) begin
      m_play[k] = 0;
      m_done[k] = 1;
    end else begin
      m_ir[k] = m_mem[k][m_pos[k]];
    end
  endtask

  task automatic model_step(input int k);
    if (m_play[k]) begin
`ifdef INSTR_STREAM_SIG_EN
      if (obs_valid) m_sig[k] = (m_sig[k] << 1) ^ (m_sig[k][15] ? POLY : 16'h0) ^ obs_in;
`endif
      if (abort) begin
        m_play[k] = 0;
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
        if (m_gap[k] == 0) finish_one(k);
      end else if (ir_ready) begin
        if (hold_of[k] == 1) finish_one(k);
        else m_gap[k] = hold_of[k] - 1;
      end
    end else begin
      if (load_we && load_addr < DEPTH) m_mem[k][load_addr] = load_data;
      if (start) begin
        m_pos[k]  = 0;
        m_sig[k]  = '0;
        m_gap[k]  = 0;
        m_len[k]  = (int'(len) > DEPTH) ? DEPTH : int'(len);
        m_play[k] = (m_len[k] > 0);
        m_done[k] = (m_len[k] == 0);
        if (m_play[k]) m_ir[k] = m_mem[k][0];
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] st;
    for (int k = 0; k < 2; k++) begin
      st = !m_play[k] ? (m_done[k] ? ST_DONE : ST_IDLE) : (m_gap[k] > 0 ? ST_HOLD : ST_ISSUE);
      chk("ir_valid", k, ir_valid[k], (m_play[k] && m_gap[k] == 0));
      chk("ir_out", k, ir_out[k], m_ir[k]);
      chk("idx", k, idx[k], m_pos[k]);
      chk("busy", k, busy[k], m_play[k]);
      chk("done", k, done[k], m_done[k]);
      chk("signature", k, signature[k], m_sig[k]);
      chk("state", k, dbg_state[k], st);
    end
  endtask

  // driver: inputs set at negedge, model steps on posedge, outputs compared at negedge
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 500) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 0, busy[0] | busy[1], 0);
  endtask

  task automatic begin_play(input int l);
    len = (AW+1)'(l);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int busy_cnt, issues, n;
    logic [5:0] pat;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, ir_valid[k], 0);
      chk("rst_irout", k, ir_out[k], 0);
      chk("rst_idx", k, idx[k], 0);
      chk("rst_done", k, done[k], 0);
      chk("rst_sig", k, signature[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      load_we   = 1'b1;
      load_addr = AW'(a);
      load_data = (a < 4) ? IR_W'(a + 1) : IR_W'($urandom_range(0, 63));
      cycle();
    end
    load_we = 1'b0;

    // four back-to-back issues
    ir_ready = 1'b1;
    begin_play(4);
    for (int s = 1; s <= 4; s++) begin
      chk("seq_valid", 0, ir_valid[0], 1);
      chk("seq_irout", 0, ir_out[0], s);
      cycle();
    end
    chk("seq_done", 0, done[0], 1);
    chk("seq_idx", 0, idx[0], 4);
    wait_idle();

    // processor stall on the second instruction
    begin_play(4);
    busy_cnt = 0;
    for (int s = 0; s < 12; s++) begin
      if (busy[0]) busy_cnt++;
      if (s >= 1 && s <= 4) begin
        chk("stall_idx", 0, idx[0], 1);
        chk("stall_irout", 0, ir_out[0], 2);
      end
      ir_ready = !(s >= 1 && s <= 3);
      cycle();
    end
    chk("stall_busy_cycles", 0, busy_cnt, 7);
    ir_ready = 1'b1;
    wait_idle();

    // HOLD=3 presentation pattern
    begin_play(2);
    pat = '0;
    for (int s = 0; s < 6; s++) begin
      pat = {pat[4:0], ir_valid[1]};
      cycle();
    end
    chk("hold_pattern", 1, pat, 6'b100100);
    chk("hold_done", 1, done[1], 1);
    wait_idle();

    // empty playback, then write+start in the same cycle
    begin_play(0);
    chk("len0_done", 0, done[0], 1);
    chk("len0_done", 1, done[1], 1);
    chk("len0_valid", 0, ir_valid[0], 0);
    load_we = 1'b1; load_addr = '0; load_data = 6'h2A;
    begin_play(1);
    load_we = 1'b0;
    chk("wr_start_irout", 0, ir_out[0], 6'h2A);
    wait_idle();

    // length clipped to DEPTH
    begin_play(60);
    issues = 0;
    n = 0;
    while (busy[0] && n < 400) begin
      if (ir_valid[0] && ir_ready) issues++;
      cycle();
      n++;
    end
    chk("clip_issues", 0, issues, 56);
    chk("clip_idx", 0, idx[0], 56);
    wait_idle();

    // abort at idx 2 with ir_ready high
    begin_play(10);
    cycle();
    cycle();
    chk("pre_abort_idx", 0, idx[0], 2);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_done", 0, done[0], 0);
    chk("abort_idx", 0, idx[0], 2);
    chk("abort_state", 0, dbg_state[0], ST_IDLE);

    // asynchronous reset mid-playback
    begin_play(10);
    for (int s = 0; s < 3; s++) cycle();
    chk("pre_rst_idx", 0, idx[0], 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", k, ir_valid[k], 0);
      chk("arst_irout", k, ir_out[k], 0);
      chk("arst_idx", k, idx[k], 0);
      chk("arst_busy", k, busy[k], 0);
      chk("arst_done", k, done[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // signature over two busy cycles
    obs_valid = 1'b1;
    obs_in = 16'h0001;
    begin_play(2);
    cycle();
    cycle();
    obs_valid = 1'b0;
    chk("sig_literal", 0, signature[0], SIG_LIT);
    wait_idle();

    // random traffic
    for (int c = 0; c < 500; c++) begin
      start     = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 29) == 0);
      ir_ready  = ($urandom_range(0, 3) != 0);
      load_we   = ($urandom_range(0, 4) == 0);
      load_addr = AW'($urandom_range(0, 63));
      load_data = IR_W'($urandom_range(0, 63));
      len       = ($urandom_range(0, 3) == 0) ? (AW+1)'($urandom_range(0, 70))
                                              : (AW+1)'($urandom_range(0, 8));
      obs_valid = ($urandom_range(0, 1) == 1);
      obs_in    = OBS_W'($urandom_range(0, 65535));
      cycle();
    end
    start = 1'b0; abort = 1'b0; load_we = 1'b0; ir_ready = 1'b1; obs_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
